// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared widths, FSM encoding and abs-difference helper for mfcc_match
package mfcc_pkg;

  localparam int NCOEF_DEF = 13;
  localparam int MEAN_W    = 16;
  localparam int DIST_W    = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Sign-extend both words to 17 bits; the 17-bit magnitude holds 65535 exactly.
  function automatic logic [MEAN_W:0] abs_diff(input logic [MEAN_W-1:0] a,
                                               input logic [MEAN_W-1:0] b);
    logic [MEAN_W:0] d;
    d = {a[MEAN_W-1], a} - {b[MEAN_W-1], b};
    return d[MEAN_W] ? (~d + 1'b1) : d;
  endfunction

endpackage

// File: rtl/mfcc_l1_acc.sv
// rtl/mfcc_l1_acc.sv - running L1 distance; sum/sum_valid appear the cycle after last
module mfcc_l1_acc
  import mfcc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MEAN_W-1:0] a,
  input  logic [MEAN_W-1:0] b,
  input  logic              en,
  input  logic              last,
  output logic [DIST_W-1:0] sum,
  output logic              sum_valid
);

  logic [DIST_W-1:0] acc_q, acc_d;
  logic [DIST_W-1:0] sum_q, sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic [MEAN_W:0]   mag;
  logic [DIST_W-1:0] total;

  always_comb begin
    mag         = abs_diff(a, b);
    total       = acc_q + DIST_W'(mag);
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    if (en) begin
      if (last) begin
        acc_d       = '0;
        sum_d       = total;
        sum_valid_d = 1'b1;
      end else begin
        acc_d = total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: rtl/mfcc_match.sv
// rtl/mfcc_match.sv - captures one MFCC mean vector and finds the nearest ROM template by L1 distance
module mfcc_match
  import mfcc_pkg::*;
#(
  parameter int NCOEF = NCOEF_DEF,
  parameter int NTPL  = 8,
  parameter int AW    = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             mfcc_means,
  input  logic                    mfcc_means_valid,
  output logic [AW-1:0]           tpl_addr,
  input  logic [15:0]             tpl_data,
  output logic                    busy,
  output logic [$clog2(NTPL)-1:0] result_idx,
  output logic [20:0]             result_dist,
  output logic                    result_valid,
  output logic                    burst_err
);

  localparam int KW = $clog2(NCOEF);
  localparam int TW = $clog2(NTPL);
  localparam int NJ = NTPL * NCOEF;

  state_e            state_q, state_d;
  logic [MEAN_W-1:0] mean_q [NCOEF];
  logic [MEAN_W-1:0] mean_d [NCOEF];
  logic [KW-1:0]     slot_q, slot_d;
  logic              ignore_q, ignore_d;
  logic              err_q, err_d;
  logic [AW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic              issue_q, issue_d;
  logic              en_q, en_d;
  logic              last_q, last_d;
  logic [KW-1:0]     kp_q, kp_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [TW-1:0]     best_idx_q, best_idx_d;
  logic [DIST_W-1:0] best_dist_q, best_dist_d;
  logic [TW-1:0]     res_idx_q, res_idx_d;
  logic [DIST_W-1:0] res_dist_q, res_dist_d;
  logic              res_valid_q, res_valid_d;
  logic [DIST_W-1:0] acc_sum;
  logic              acc_sum_valid;

  mfcc_l1_acc u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (mean_q[kp_q]),
    .b         (tpl_data),
    .en        (en_q),
    .last      (last_q),
    .sum       (acc_sum),
    .sum_valid (acc_sum_valid)
  );

  always_comb begin
    state_d     = state_q;
    mean_d      = mean_q;
    slot_d      = slot_q;
    ignore_d    = ignore_q;
    err_d       = 1'b0;
    j_d         = j_q;
    k_d         = k_q;
    issue_d     = issue_q;
    en_d        = 1'b0;
    last_d      = 1'b0;
    kp_d        = kp_q;
    tcnt_d      = tcnt_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    res_idx_d   = res_idx_q;
    res_dist_d  = res_dist_q;
    res_valid_d = 1'b0;

    // ignore_q marks a valid run already accounted for (tail of a full burst or a flagged overlap)
    if (!mfcc_means_valid) ignore_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mfcc_means_valid && !ignore_q) begin
          mean_d[0] = mfcc_means;
          slot_d    = KW'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (mfcc_means_valid) begin
          mean_d[slot_q] = mfcc_means;
          slot_d         = slot_q + 1'b1;
          if (slot_q == KW'(NCOEF - 1)) begin
            state_d  = COMPUTE;
            ignore_d = 1'b1;
            j_d      = '0;
            k_d      = '0;
            issue_d  = 1'b1;
            tcnt_d   = '0;
          end
        end else begin
          err_d   = 1'b1;
          slot_d  = '0;
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        if (issue_q) begin
          en_d   = 1'b1;
          kp_d   = k_q;
          last_d = (k_q == KW'(NCOEF - 1));
          k_d    = last_d ? '0 : k_q + 1'b1;
          j_d    = j_q + 1'b1;
          if (j_q == AW'(NJ - 1)) begin
            issue_d = 1'b0;
            j_d     = '0;
          end
        end
        if (acc_sum_valid) begin
          if (tcnt_q == '0 || acc_sum < best_dist_q) begin
            best_idx_d  = tcnt_q;
            best_dist_d = acc_sum;
          end
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == TW'(NTPL - 1)) begin
            state_d     = DONE;
            res_idx_d   = best_idx_d;
            res_dist_d  = best_dist_d;
            res_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == COMPUTE || state_q == DONE) && mfcc_means_valid && !ignore_q) begin
      err_d    = 1'b1;
      ignore_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NCOEF; i++) mean_q[i] <= '0;
      slot_q      <= '0;
      ignore_q    <= 1'b0;
      err_q       <= 1'b0;
      j_q         <= '0;
      k_q         <= '0;
      issue_q     <= 1'b0;
      en_q        <= 1'b0;
      last_q      <= 1'b0;
      kp_q        <= '0;
      tcnt_q      <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      res_idx_q   <= '0;
      res_dist_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mean_q      <= mean_d;
      slot_q      <= slot_d;
      ignore_q    <= ignore_d;
      err_q       <= err_d;
      j_q         <= j_d;
      k_q         <= k_d;
      issue_q     <= issue_d;
      en_q        <= en_d;
      last_q      <= last_d;
      kp_q        <= kp_d;
      tcnt_q      <= tcnt_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      res_idx_q   <= res_idx_d;
      res_dist_q  <= res_dist_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign tpl_addr     = issue_q ? j_q : '0;
  assign busy         = (state_q == CAPTURE) || (state_q == COMPUTE);
  assign result_idx   = res_idx_q;
  assign result_dist  = res_dist_q;
  assign result_valid = res_valid_q;
  assign burst_err    = err_q;

endmodule

// File: tb/tb_mfcc_match.sv
// tb/tb_mfcc_match.sv - directed bench for mfcc_match with a registered template ROM model
module tb_mfcc_match;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mfcc_means;
  logic        mfcc_means_valid;
  logic [6:0]  tpl_addr;
  logic [15:0] tpl_data;
  logic        busy;
  logic [2:0]  result_idx;
  logic [20:0] result_dist;
  logic        result_valid;
  logic        burst_err;

  logic [15:0] rom [0:127];
  logic [15:0] mean_v [13];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) tpl_data <= rom[tpl_addr];

  mfcc_match dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mfcc_means       (mfcc_means),
    .mfcc_means_valid (mfcc_means_valid),
    .tpl_addr         (tpl_addr),
    .tpl_data         (tpl_data),
    .busy             (busy),
    .result_idx       (result_idx),
    .result_dist      (result_dist),
    .result_valid     (result_valid),
    .burst_err        (burst_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic drive_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mfcc_means_valid = 1'b1;
      mfcc_means       = mean_v[i];
    end
    @(posedge clk); #1;
    mfcc_means_valid = 1'b0;
    mfcc_means       = 16'h0;
  endtask

  // Runs ncyc cycles counted from cycle 1 after the last sampled burst word.
  task automatic run_vec(input string name, input int ncyc, input int ovl_at, input int rst_at,
                         input bit timing, output bit seen, output int rcyc, output int errs);
    seen = 1'b0;
    rcyc = 0;
    errs = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      mfcc_means_valid = (cyc >= ovl_at) && (cyc < ovl_at + 13);
      mfcc_means       = 16'h1234;
      rst_n            = (cyc != rst_at);
      @(negedge clk);
      if (result_valid && !seen) begin
        seen = 1'b1;
        rcyc = cyc;
      end
      if (burst_err) errs++;
      if (timing) begin
        if (cyc == 1)   chk({name, "_addr_c1"}, 32'(tpl_addr), 32'd0);
        if (cyc == 2)   chk({name, "_addr_c2"}, 32'(tpl_addr), 32'd1);
        if (cyc == 104) chk({name, "_addr_c104"}, 32'(tpl_addr), 32'd103);
        if (cyc == 105) chk({name, "_addr_c105"}, 32'(tpl_addr), 32'd0);
        if (cyc == 106) chk({name, "_busy_c106"}, 32'(busy), 32'd1);
        if (cyc == 107) chk({name, "_busy_c107"}, 32'(busy), 32'd0);
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        chk({name, "_rst_busy"}, 32'(busy), 32'd0);
        chk({name, "_rst_valid"}, 32'(result_valid), 32'd0);
        chk({name, "_rst_err"}, 32'(burst_err), 32'd0);
        chk({name, "_rst_addr"}, 32'(tpl_addr), 32'd0);
        chk({name, "_rst_idx"}, 32'(result_idx), 32'd0);
        chk({name, "_rst_dist"}, 32'(result_dist), 32'd0);
      end
      @(posedge clk); #1;
    end
    mfcc_means_valid = 1'b0;
    mfcc_means       = 16'h0;
    rst_n            = 1'b1;
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic fill_identity();
    for (int k = 0; k < 13; k++) mean_v[k] = 16'(k * 1000 - 6000);
    for (int t = 0; t < 8; t++)
      for (int k = 0; k < 13; k++)
        rom[t*13+k] = (t == 3) ? mean_v[k] : mean_v[k] + 16'd1;
  endtask

  task automatic fill_extreme();
    for (int k = 0; k < 13; k++) mean_v[k] = 16'h7FFF;
    for (int t = 0; t < 8; t++)
      for (int k = 0; k < 13; k++)
        rom[t*13+k] = (t == 0) ? 16'h8000 : 16'h7FFF;
    rom[5*13+4] = 16'h7FFE;
  endtask

  task automatic fill_tie();
    for (int k = 0; k < 13; k++) mean_v[k] = 16'(k * 100);
    for (int t = 0; t < 8; t++)
      for (int k = 0; k < 13; k++)
        rom[t*13+k] = (t == 2 || t == 6) ? mean_v[k] : mean_v[k] + 16'd5;
    rom[2*13+0] = mean_v[0] + 16'd40;
    rom[6*13+5] = mean_v[5] - 16'd40;
  endtask

  task automatic fill_descend();
    for (int k = 0; k < 13; k++) mean_v[k] = 16'(-k * 500);
    for (int t = 0; t < 8; t++)
      for (int k = 0; k < 13; k++)
        rom[t*13+k] = mean_v[k] - 16'(8 - t);
  endtask

  bit seen;
  int rcyc;
  int errs;

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0;
    rst_n            = 1'b0;
    mfcc_means       = 16'h0;
    mfcc_means_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_idx", 32'(result_idx), 32'd0);
    chk("reset_dist", 32'(result_dist), 32'd0);
    chk("reset_err", 32'(burst_err), 32'd0);
    chk("reset_addr", 32'(tpl_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill_identity();
    drive_burst(13);
    run_vec("ident", 112, 1000, 0, 1'b1, seen, rcyc, errs);
    chk("ident_seen", 32'(seen), 32'd1);
    chk("ident_cycle", 32'(rcyc), 32'd107);
    chk("ident_errs", 32'(errs), 32'd0);
    chk("ident_idx", 32'(result_idx), 32'd3);
    chk("ident_dist", 32'(result_dist), 32'd0);

    fill_extreme();
    drive_burst(13);
    run_vec("extreme", 112, 1000, 0, 1'b0, seen, rcyc, errs);
    chk("extreme_cycle", 32'(rcyc), 32'd107);
    chk("extreme_idx", 32'(result_idx), 32'd1);
    chk("extreme_dist", 32'(result_dist), 32'd0);

    fill_tie();
    drive_burst(13);
    run_vec("tie", 112, 1000, 0, 1'b0, seen, rcyc, errs);
    chk("tie_cycle", 32'(rcyc), 32'd107);
    chk("tie_idx", 32'(result_idx), 32'd2);
    chk("tie_dist", 32'(result_dist), 32'd40);

    fill_descend();
    drive_burst(7);
    run_vec("short", 20, 1000, 0, 1'b0, seen, rcyc, errs);
    chk("short_errs", 32'(errs), 32'd1);
    chk("short_seen", 32'(seen), 32'd0);
    drive_burst(13);
    run_vec("after_short", 112, 1000, 0, 1'b0, seen, rcyc, errs);
    chk("after_short_cycle", 32'(rcyc), 32'd107);
    chk("after_short_errs", 32'(errs), 32'd0);
    chk("after_short_idx", 32'(result_idx), 32'd7);
    chk("after_short_dist", 32'(result_dist), 32'd13);

    fill_identity();
    drive_burst(13);
    run_vec("overlap", 112, 50, 0, 1'b0, seen, rcyc, errs);
    chk("overlap_errs", 32'(errs), 32'd1);
    chk("overlap_cycle", 32'(rcyc), 32'd107);
    chk("overlap_idx", 32'(result_idx), 32'd3);
    chk("overlap_dist", 32'(result_dist), 32'd0);

    fill_tie();
    drive_burst(13);
    run_vec("rst_mid", 112, 1000, 60, 1'b0, seen, rcyc, errs);
    chk("rst_mid_seen", 32'(seen), 32'd0);
    chk("rst_mid_errs", 32'(errs), 32'd0);
    fill_extreme();
    drive_burst(13);
    run_vec("after_rst", 112, 1000, 0, 1'b0, seen, rcyc, errs);
    chk("after_rst_cycle", 32'(rcyc), 32'd107);
    chk("after_rst_idx", 32'(result_idx), 32'd1);
    chk("after_rst_dist", 32'(result_dist), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mfcc_match.md
# mfcc_match

Consumer of the per-utterance MFCC mean burst. It captures the 13 signed mean words and computes the L1 distance to each of NTPL stored templates, read serially from an external synchronous ROM. It reports the index and distance of the nearest template. It sits directly downstream of the MFCC averaging stage and is the final stage of the keyword-recognition path.

## Interface
Parameters:
- NCOEF, 13, coefficients per mean vector and per template
- NTPL, 8, number of templates in ROM
- AW, 7, template ROM address width; must satisfy 2^AW ≥ NTPL·NCOEF

Ports:
- clk, input, 1, clock
- rst_n, input, 1, reset: synchronous, active-low
- mfcc_means, input, 16, signed mean word, two's complement
- mfcc_means_valid, input, 1, word strobe; one burst is NCOEF consecutive high cycles
- tpl_addr, output, AW, ROM address: template t, coefficient k at t·NCOEF+k
- tpl_data, input, 16, signed template word; valid exactly one cycle after its address
- busy, output, 1, high in CAPTURE and COMPUTE
- result_idx, output, $clog2(NTPL), nearest template index
- result_dist, output, 21, L1 distance of the nearest template
- result_valid, output, 1, one-cycle pulse; result_idx and result_dist are held until the next result
- burst_err, output, 1, one-cycle pulse on a short or overlapping burst

## Operation
- Reset values: all outputs are 0. The FSM goes to IDLE. The capture buffer and accumulators are cleared.
- IDLE: the first cycle with mfcc_means_valid high stores the word in slot 0 and moves to CAPTURE.
- CAPTURE: each valid cycle stores the next slot.
- The 13th word moves the FSM to COMPUTE.
- If valid drops before slot 12 is filled, the FSM pulses burst_err, returns to IDLE and discards the partial vector.
- COMPUTE: the address counter j steps 0 to NTPL·NCOEF−1, one step per cycle, with no stalls.
- Each returned word is processed as follows:
  - d = mean[k] − tpl (17-bit signed).
  - |d| is 17-bit unsigned.
  - |d| is added to a 21-bit accumulator. The accumulator cannot overflow: 13·2^16 < 2^21.
- After the last coefficient of template t, the accumulator is compared with the best-so-far distance and then cleared.
- Template 0 always loads the best-so-far registers.
- A later template replaces the best only if it is strictly less, so on a tie the lowest index wins.
- DONE: the FSM registers best_idx and best_dist into the result outputs and pulses result_valid for one cycle, then returns to IDLE.
- mfcc_means_valid high during COMPUTE or DONE pulses burst_err once per offending burst. The word is ignored and the computation is not disturbed.
- Words beyond the 13th in a continuous burst are ignored; no error is raised.
- rst_n low in any state aborts the operation immediately. No result_valid is produced for the aborted burst.

## Timing
- Cycle numbering: cycle 1 is the first cycle after the clock edge that samples the 13th word.
- tpl_addr = j during cycle j+1.
- tpl_data for address j is consumed at the end of cycle j+2.
- The compare for template t completes at the end of cycle t·NCOEF+NCOEF+2.
- result_valid is high in cycle NTPL·NCOEF+3, which is cycle 107 for the defaults.
- busy:
  - Rises in the cycle after the first captured word.
  - Falls in the same cycle that result_valid is high.
- tpl_addr is held at 0 outside COMPUTE.
- The earliest next burst is accepted in the cycle after result_valid.

## Structure
- Shared package mfcc_pkg holds:
  - NCOEF_DEF = 13
  - MEAN_W = 16
  - DIST_W = 21
  - the FSM state encoding: IDLE, CAPTURE, COMPUTE, DONE
- Sub-module mfcc_l1_acc holds the absolute-difference accumulator:
  - Inputs: a, b, en, last.
  - Outputs: sum and sum_valid, asserted one cycle after last.
- The top level holds:
  - the capture register file (NCOEF×16)
  - the FSM
  - the address and coefficient counters
  - the argmin registers

## Test plan
- Identity match:
  - Stimulus: ROM template 3 equals the burst; every other template is offset by +1 per coefficient.
  - Required response: result_idx=3, result_dist=0, result_valid in cycle 107.
- Extreme values:
  - Stimulus: burst of 13 × 0x7FFF; template 0 is all 0x8000 and the rest are all 0x7FFF except template 5, which differs by 1 in a single coefficient.
  - Required response: template 0 gives distance 13·65535=851955 with no overflow, and result is idx=1, dist=0.
- Tie:
  - Stimulus: templates 2 and 6 both at distance 40, all others greater.
  - Required response: result_idx=2, result_dist=40.
- Short burst:
  - Stimulus: valid is high for 7 cycles, then low.
  - Required response: burst_err pulses once, no result_valid, and busy is low.
  - A following full burst must then produce a correct result.
- Overlap:
  - Stimulus: a second burst starts in cycle 50 of COMPUTE.
  - Required response: one burst_err pulse, and the first result is unchanged at cycle 107.
- Reset mid-COMPUTE:
  - Stimulus: rst_n low for 1 cycle in cycle 60.
  - Required response: all outputs are 0 on the next cycle, no result_valid, and the next burst is processed normally.
